uart_tx: RTL and testbench

- Fixed-format UART transmitter: 8 data bits, LSB first, 1 start bit (0), 1 stop bit (1), no parity.
- Contains a free-running baud-rate strobe generator and exports the strobe as `tick` for monitoring and synchronisation.
- Sits between a byte-producing client (start/busy handshake) and the serial line.

---
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Fixed-format UART transmitter: 1 start bit (0), 8 data bits LSB first,
// 1 stop bit (1), no parity. A free-running baud generator produces a
// one-clock strobe every CLKS_PER_BIT clocks. Every line change is registered
// on the clock edge where that strobe is already high, so the line is stable
// across each rising edge of the strobe.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   tx_data   in   byte to send, sampled only when a start is accepted
//   tx_start  in   level-sensitive send request; ignored while busy
//   tx_out    out  serial line, idles high
//   tx_busy   out  high from start acceptance through the end of the stop bit
//   tick      out  registered one-clock baud strobe
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

    // -------------------------------------------------------------------------
    // Baud generator: runs continuously, idle or busy.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            // Strobe rises on the same edge the counter wraps to zero.
            tick_q <= (cnt_q == CNT_LAST);
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q,   idx_d;
    logic       tx_q,    tx_d;
    logic       busy_q,  busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold value first so no path through the
        // case statement leaves one unassigned (which would infer a latch).
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d = tx_data;
                    busy_d  = 1'b1;
                    // Always wait for the next strobe, even if one is present
                    // now, so the start bit gets a full bit period.
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tick_q) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick_q) begin
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick_q) begin
                    if (idx_q != 3'd7) begin
                        // Shift right so the next data bit is always at [0];
                        // drive it straight from [1] of the current value.
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick_q) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_out  = tx_q;
    assign tx_busy = busy_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx with a short bit period (8 clocks). Frames are
// captured by sampling tx_out whenever tick is high, which is the line value
// stable across the rising edge of that tick; ticks 2..11 after busy rises
// hold {stop, data[7:0], start}. Expected frame patterns are written out by
// hand as {1, data, 0}.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB    = 8;
    localparam int BUDGET = 14 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_out;
    logic       tx_busy;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx #(
        .CLK_FREQ (80),
        .BAUD     (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Must be called at a negedge. Waits for busy, then records the line at
    // ticks 2..11 and checks busy timing around the end of the frame.
    task automatic capture_frame(input logic [9:0] exp, input string tag);
        logic [9:0] got     = '0;
        int         ticks   = 0;
        int         cyc     = 0;
        logic       busy_ok = 1'b1;

        while (tx_busy !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_busy_rise"}, 32'(tx_busy), 32'd1);

        cyc = 0;
        while (ticks < 11 && cyc < BUDGET) begin
            if (tx_busy !== 1'b1) busy_ok = 1'b0;
            if (tick === 1'b1) begin
                ticks++;
                if (ticks >= 2) got[ticks-2] = tx_out;
            end
            if (ticks < 11) begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_tick_count"}, 32'(ticks), 32'd11);
        check({tag, "_bits"}, 32'(got), 32'(exp));
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
        check({tag, "_busy_fall"}, 32'(tx_busy), 32'd0);
        check({tag, "_line_idle"}, 32'(tx_out), 32'd1);
    endtask

    // Hand-computed frames, {stop, data, start}, bit k at index k.
    logic [7:0] vec_data [3] = '{8'h00, 8'hFF, 8'hAA};
    logic [9:0] vec_exp  [3] = '{10'b1000000000, 10'b1111111110, 10'b1101010100};

    initial begin
        logic ok_line, ok_busy, ok_tick, quiet;
        int   n;

        // ---------------- reset held ----------------
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        ok_line  = 1'b1;
        ok_busy  = 1'b1;
        ok_tick  = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (tx_out  !== 1'b1) ok_line = 1'b0;
            if (tx_busy !== 1'b0) ok_busy = 1'b0;
            if (tick    !== 1'b0) ok_tick = 1'b0;
        end
        check("rst_tx_out", 32'(ok_line), 32'd1);
        check("rst_busy",   32'(ok_busy), 32'd1);
        check("rst_tick",   32'(ok_tick), 32'd1);
        rst = 1'b0;

        // ---------------- tick spacing ----------------
        n = 0;
        while (tick !== 1'b1 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", 32'(tick), 32'd1);
        @(negedge clk);
        check("tick_width", 32'(tick), 32'd0);
        n = 1;
        while (tick !== 1'b1 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        check("tick_spacing", 32'(n), 32'(CPB));

        // ---------------- 0x4D, ignored restart, tx_data change ----------------
        @(negedge clk);
        tx_data  = 8'h4D;
        tx_start = 1'b1;
        fork
            capture_frame(10'b1010011010, "f4d");
            begin
                repeat (2) @(negedge clk);
                tx_start = 1'b0;
                repeat (3 * CPB) @(negedge clk);
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        quiet = 1'b1;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (tx_busy !== 1'b0 || tx_out !== 1'b1) quiet = 1'b0;
        end
        check("no_queued_frame", 32'(quiet), 32'd1);

        // ---------------- 0x00 / 0xFF / 0xAA ----------------
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_data  = vec_data[i];
            tx_start = 1'b1;
            fork
                capture_frame(vec_exp[i], $sformatf("v%0h", vec_data[i]));
                begin
                    @(negedge clk);
                    tx_start = 1'b0;
                end
            join
            repeat (2 * CPB) @(negedge clk);
        end

        // ---------------- start coincident with tick ----------------
        n = 0;
        while (tick !== 1'b1 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        fork
            capture_frame(10'b1010110100, "coinc");
            begin
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        repeat (CPB) @(negedge clk);

        // ---------------- reset mid-frame ----------------
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        n = 0;
        begin
            int ticks = 0;
            while (ticks < 4 && n < BUDGET) begin
                @(negedge clk);
                n++;
                if (tick === 1'b1) ticks++;
            end
        end
        check("mid_pre_line", 32'(tx_out), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_line", 32'(tx_out), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tx_data  = 8'h4D;
        tx_start = 1'b1;
        fork
            capture_frame(10'b1010011010, "post_rst");
            begin
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        repeat (CPB) @(negedge clk);

        // ---------------- back-to-back with held start ----------------
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        fork
            capture_frame(10'b1001111000, "b2b_1");
            begin
                repeat (2 * CPB) @(negedge clk);
                tx_data = 8'hC3;
            end
        join
        @(negedge clk);
        check("b2b_rearm", 32'(tx_busy), 32'd1);
        fork
            capture_frame(10'b1110000110, "b2b_2");
            begin
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        quiet = 1'b1;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (tx_busy !== 1'b0) quiet = 1'b0;
        end
        check("b2b_stop", 32'(quiet), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
